// File: rtl/wb_writer.sv
// wb_writer: write-back stage arbitrating ALU and load results onto one register-file write port,
// with load byte/halfword extraction, a one-entry ALU skid buffer, x0 drop and a retire counter.
module wb_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  ld_valid,
   input  logic [ADDR_WIDTH-1:0] ld_rd,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic [2:0]            ld_funct3,
   input  logic [1:0]            ld_addr_lo,
   output logic                  w_enable,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [CNT_WIDTH-1:0]  retire_cnt
);
   logic                  skid_full, skid_full_n, rdy;
   logic [ADDR_WIDTH-1:0] skid_rd, win_rd;
   logic [DATA_WIDTH-1:0] skid_data, win_data, ld_fmt;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic                  alu_acc, win, skid_load;

   // Ready is a flop so it never depends combinationally on either valid.
   assign alu_ready = rdy;

   always_comb begin
      ld_byte     = ld_data[{ld_addr_lo, 3'b000} +: 8];
      ld_half     = ld_addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
      ld_fmt      = ld_funct3 == 3'b000 ? {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte} :
                    ld_funct3 == 3'b001 ? {{(DATA_WIDTH-16){ld_half[15]}}, ld_half} :
                    ld_funct3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, ld_byte} :
                    ld_funct3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, ld_half} : ld_data;
      alu_acc     = alu_valid & rdy;
      win         = ld_valid | skid_full | alu_acc;
      win_rd      = ld_valid ? ld_rd : skid_full ? skid_rd : alu_rd;
      win_data    = ld_valid ? ld_fmt : skid_full ? skid_data : alu_data;
      skid_load   = ld_valid & alu_acc;
      skid_full_n = ld_valid & (skid_full | alu_acc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_full  <= 1'b0;
         rdy        <= 1'b0;
         skid_rd    <= '0;
         skid_data  <= '0;
         w_enable   <= 1'b0;
         w_addr     <= '0;
         w_data     <= '0;
         retire_cnt <= '0;
      end else begin
         skid_full <= skid_full_n;
         rdy       <= ~skid_full_n;
         if (skid_load) begin
            skid_rd   <= alu_rd;
            skid_data <= alu_data;
         end
         w_enable <= win && win_rd != '0;
         // x0 winners retire but leave the write port registers untouched.
         if (win && win_rd != '0) begin
            w_addr <= win_rd;
            w_data <= win_data;
         end
         if (win) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed self-checking bench for wb_writer; a 4-bit-counter copy checks wraparound.
module tb_wb_writer;
   logic        clk = 1'b0, rst = 1'b0;
   logic        alu_valid = 1'b0, ld_valid = 1'b0;
   logic [4:0]  alu_rd = '0, ld_rd = '0;
   logic [31:0] alu_data = '0, ld_data = '0;
   logic [2:0]  ld_funct3 = '0;
   logic [1:0]  ld_addr_lo = '0;
   logic        alu_ready, w_enable, alu_ready_s, w_enable_s;
   logic [4:0]  w_addr, w_addr_s;
   logic [31:0] w_data, w_data_s, retire_cnt;
   logic [3:0]  retire_cnt_s;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   wb_writer dut (
      .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_ready(alu_ready), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
      .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .w_enable(w_enable), .w_addr(w_addr),
      .w_data(w_data), .retire_cnt(retire_cnt)
   );

   wb_writer #(.CNT_WIDTH(4)) dut_s (
      .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_ready(alu_ready_s), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
      .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .w_enable(w_enable_s), .w_addr(w_addr_s),
      .w_data(w_data_s), .retire_cnt(retire_cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_en"}, 32'(w_enable), 32'(en));
      chk({tag, "_addr"}, 32'(w_addr), 32'(a));
      chk({tag, "_data"}, w_data, d);
   endtask

   initial begin
      // reset state
      tick;
      wr("rst", 1'b0, 5'd0, 32'h0);
      chk("rst_cnt", retire_cnt, 32'd0);
      chk("rst_ready", 32'(alu_ready), 32'd0);
      rst = 1'b1;
      tick;
      chk("post_rst_ready", 32'(alu_ready), 32'd1);
      // single ALU result
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
      tick;
      alu_valid = 1'b0;
      wr("alu1", 1'b1, 5'd3, 32'hDEADBEEF);
      chk("alu1_cnt", retire_cnt, 32'd1);
      tick;
      wr("alu1_idle", 1'b0, 5'd3, 32'hDEADBEEF);
      // collision: load wins, ALU goes to the skid
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h11;
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h22; ld_funct3 = 3'b010;
      tick;
      alu_valid = 1'b0; ld_valid = 1'b0;
      wr("col_ld", 1'b1, 5'd7, 32'h22);
      chk("col_ready0", 32'(alu_ready), 32'd0);
      tick;
      wr("col_alu", 1'b1, 5'd4, 32'h11);
      chk("col_ready1", 32'(alu_ready), 32'd1);
      chk("col_cnt", retire_cnt, 32'd3);
      tick;
      chk("col_idle_en", 32'(w_enable), 32'd0);
      // load extension
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h80FF7F01; ld_funct3 = 3'b000; ld_addr_lo = 2'd3;
      tick;
      wr("lb3", 1'b1, 5'd9, 32'hFFFFFF80);
      ld_funct3 = 3'b100; ld_addr_lo = 2'd2;
      tick;
      wr("lbu2", 1'b1, 5'd9, 32'h000000FF);
      ld_funct3 = 3'b001; ld_addr_lo = 2'd2;
      tick;
      wr("lh2", 1'b1, 5'd9, 32'hFFFF80FF);
      ld_funct3 = 3'b101; ld_addr_lo = 2'd0;
      tick;
      wr("lhu0", 1'b1, 5'd9, 32'h00007F01);
      ld_valid = 1'b0; ld_funct3 = 3'b010;
      chk("ld_cnt", retire_cnt, 32'd7);
      // x0 drop still retires
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      tick;
      alu_valid = 1'b0;
      wr("x0", 1'b0, 5'd9, 32'h00007F01);
      chk("x0_cnt", retire_cnt, 32'd8);
      // six back-to-back x0 results bring the count to 14 (0xE in the 4-bit copy)
      alu_valid = 1'b1;
      repeat (6) tick;
      alu_valid = 1'b0;
      chk("pre_cnt", retire_cnt, 32'd14);
      chk("pre_cnt_s", 32'(retire_cnt_s), 32'hE);
      chk("pre_en", 32'(w_enable), 32'd0);
      // back-pressure: three loads while ALU keeps presenting
      alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD;
      ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA;
      chk("bp_ready_pre", 32'(alu_ready), 32'd1);
      tick;
      wr("bp_ld0", 1'b1, 5'd10, 32'hA);
      chk("bp_ready0", 32'(alu_ready), 32'd0);
      ld_rd = 5'd11; ld_data = 32'hB;
      tick;
      wr("bp_ld1", 1'b1, 5'd11, 32'hB);
      chk("bp_ready1", 32'(alu_ready), 32'd0);
      ld_rd = 5'd12; ld_data = 32'hC;
      tick;
      wr("bp_ld2", 1'b1, 5'd12, 32'hC);
      chk("bp_ready2", 32'(alu_ready), 32'd0);
      ld_valid = 1'b0; alu_valid = 1'b0;
      tick;
      wr("bp_alu", 1'b1, 5'd13, 32'hD);
      chk("bp_ready3", 32'(alu_ready), 32'd1);
      chk("bp_cnt", retire_cnt, 32'd18);
      chk("bp_cnt_wrap", 32'(retire_cnt_s), 32'h2);
      tick;
      chk("bp_one_alu", 32'(w_enable), 32'd0);
      chk("bp_cnt_hold", retire_cnt, 32'd18);
      // reset while the skid holds rd=5
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
      ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
      tick;
      alu_valid = 1'b0; ld_valid = 1'b0;
      wr("mr_ld", 1'b1, 5'd6, 32'h66);
      chk("mr_ready0", 32'(alu_ready), 32'd0);
      rst = 1'b0;
      #1;
      wr("mr_async", 1'b0, 5'd0, 32'h0);
      chk("mr_cnt", retire_cnt, 32'd0);
      chk("mr_cnt_s", 32'(retire_cnt_s), 32'd0);
      tick;
      rst = 1'b1;
      tick;
      chk("mr_ready1", 32'(alu_ready), 32'd1);
      wr("mr_no_rd5_a", 1'b0, 5'd0, 32'h0);
      tick;
      wr("mr_no_rd5_b", 1'b0, 5'd0, 32'h0);
      chk("mr_cnt_after", retire_cnt, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back stage that drives the register file's single write port (w_enable, w_addr, w_data) from two producers: the ALU result channel and the load-return channel.
- Load data is byte/halfword-extracted and sign/zero-extended before write.
- Results are serialised onto the one write port with fixed priority; a one-entry skid buffer absorbs ALU results that lose arbitration.
- Writes to x0 are dropped; a retire counter is maintained.

Parameters:
- DATA_WIDTH, 32, register data width (RegBus).
- ADDR_WIDTH, 5, register address width (RegAddrBus).
- CNT_WIDTH, 32, width of retire counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- alu_valid  in  1  ALU result present.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready.
- ld_valid  in  1  load return present; always accepted.
- ld_rd  in  ADDR_WIDTH  load destination register.
- ld_data  in  DATA_WIDTH  raw aligned 32-bit memory word.
- ld_funct3  in  3  load type (RV32I funct3).
- ld_addr_lo  in  2  byte offset of load address.
- w_enable  out  1  register file write enable.
- w_addr  out  ADDR_WIDTH  register file write address.
- w_data  out  DATA_WIDTH  register file write data.
- retire_cnt  out  CNT_WIDTH  count of completed write-backs.

Behaviour:
Reset (rst=0, asynchronous):
- w_enable=0, w_addr=0, w_data=0, retire_cnt=0, skid empty.
- alu_ready=0 while in reset.
- Deassertion takes effect at the next rising edge; an in-flight skid entry is discarded.

alu_ready:
- alu_ready = !skid_full, from registered state only.
- There is no combinational path from alu_valid or ld_valid to alu_ready.

Arbitration (per cycle, one winner drives the write slot):
- Priority 1: ld_valid.
- Priority 2: skid entry.
- Priority 3: accepted ALU result.
- ALU result accepted while ld_valid=1 is stored in the skid (skid was empty, since alu_ready=1).
- Skid full and ld_valid=0: skid drains this cycle. No new ALU accept this cycle (alu_ready=0), so the skid is empty next cycle.
- Skid full and ld_valid=1: skid holds and alu_ready stays 0.

Output register:
- The winner is registered at the rising edge.
- w_enable=1 for exactly one cycle, the cycle after the winning edge, if winner rd != 0.
- Winner with rd == 0: w_enable=0, w_addr/w_data hold previous values, transaction still counts as retired.
- No winner: w_enable=0, w_addr/w_data hold.
- Latency: 1 cycle from acceptance to w_enable when not blocked; +1 cycle per stalled cycle in the skid.

Load formatting (byte index b = ld_addr_lo, half index h = ld_addr_lo[1]):
- 000 LB: sign-extend byte b.
- 001 LH: sign-extend half h (ld_addr_lo[0] ignored).
- 010 LW: word unchanged (ld_addr_lo ignored).
- 100 LBU: zero-extend byte b.
- 101 LHU: zero-extend half h.
- Other funct3: treated as LW.

retire_cnt:
- Increments by 1 on each edge where a winner exists; rd=0 winners included.
- Wraps modulo 2^CNT_WIDTH with no saturation.

Ordering:
- In-order delivery is guaranteed only per producer.
- Cross-producer hazards are resolved upstream.

Test Plan:
1. Reset mid-operation: skid holding rd=5, assert rst=0 asynchronously -> w_enable, w_addr, w_data, retire_cnt go to 0 immediately; after release, rd=5 is never written and alu_ready=1.
2. Single ALU: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF for one cycle -> next cycle w_enable=1, w_addr=3, w_data=0xDEADBEEF; retire_cnt=1; w_enable=0 after.
3. Collision: same cycle alu(rd=4, 0x11) and ld(rd=7, LW, 0x22) -> cycle+1: write rd7=0x22, alu_ready=0; cycle+2: write rd4=0x11, alu_ready=1; retire_cnt=2.
4. Load extension: ld_data=0x80FF7F01, funct3=000, addr_lo=3 -> w_data=0xFFFFFF80. funct3=100, addr_lo=2 -> 0x000000FF. funct3=001, addr_lo=2 -> 0xFFFF80FF. funct3=101, addr_lo=0 -> 0x00007F01.
5. x0 drop: alu_rd=0, alu_data=0x1234 -> w_enable stays 0 and w_addr/w_data unchanged; retire_cnt increments by 1.
6. Back-pressure stream: ld_valid=1 for 3 cycles while alu_valid=1 continuously -> exactly one ALU result accepted into the skid, alu_ready=0 for those 3 cycles; 4 writes total in order ld, ld, ld, alu; counter preloaded to 0xFFFFFFFE wraps to 0x00000002.
